// File: rtl/tdm_mux_pkg.sv
// Shared constants and helpers for the TDM slot multiplexer.
// Mode encodings and the channel-index width derivation live here.
package tdm_mux_pkg;

  localparam logic TDM_FIXED = 1'b0;
  localparam logic TDM_SKIP  = 1'b1;

  // Index width that stays at least one bit wide even for tiny channel counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_mux_rr_pick.sv
// Combinational wrap-around priority picker: the first asserted request at or
// after base, wrapping past N-1 back to 0.
module rr_pick
  import tdm_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int CH_W = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] base,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [CH_W-1:0] cand [N];

  // cand[gi] is the channel visited gi steps after base, reduced modulo N.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [CH_W:0] sum;
    assign sum      = {1'b0, base} + (CH_W+1)'(gi);
    assign cand[gi] = (sum >= (CH_W+1)'(N)) ? CH_W'(sum - (CH_W+1)'(N)) : sum[CH_W-1:0];
  end

  // Walk from the far end so the nearest request overwrites earlier hits.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/tdm_slot_mux.sv
// Registered TDM merge of NUM_CH channels onto one valid/ready stream, with
// fixed-slot rotation (idle slots emit DEFAULT_VAL) or skip-idle round-robin.
module tdm_slot_mux
  import tdm_mux_pkg::*;
#(
  parameter  int               WIDTH       = 4,
  parameter  int               NUM_CH      = 4,
  parameter  logic [WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int               CH_W        = clog2_min1(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_default
);

  logic [CH_W-1:0]  ptr_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [CH_W-1:0]  out_ch_reg;
  logic             out_default_reg;

  logic             load;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic [CH_W-1:0]  sel_idx;
  logic             sel_hit;
  logic [WIDTH-1:0] sel_data;
  logic [CH_W-1:0]  ptr_inc;
  logic [CH_W-1:0]  gnt_inc;

  rr_pick #(.N(NUM_CH)) u_pick (
    .req     (in_valid),
    .base    (ptr_reg),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign load     = !out_valid_reg || out_ready;
  assign sel_idx  = (mode == TDM_SKIP) ? gnt_idx : ptr_reg;
  assign sel_hit  = (mode == TDM_SKIP) ? gnt_any : in_valid[ptr_reg];
  assign sel_data = in_data[int'(sel_idx)*WIDTH +: WIDTH];
  assign ptr_inc  = (ptr_reg == CH_W'(NUM_CH - 1)) ? '0 : ptr_reg + 1'b1;
  assign gnt_inc  = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

  // A channel is acknowledged only when its sample is loaded this very cycle.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
    assign in_ready[gi] = load && !rst && sel_hit && (sel_idx == CH_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg         <= '0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= DEFAULT_VAL;
      out_ch_reg      <= '0;
      out_default_reg <= 1'b0;
    end else if (load) begin
      if (mode == TDM_FIXED) begin
        out_valid_reg   <= 1'b1;
        out_ch_reg      <= ptr_reg;
        out_data_reg    <= sel_hit ? sel_data : DEFAULT_VAL;
        out_default_reg <= !sel_hit;
        ptr_reg         <= ptr_inc;
      end else if (gnt_any) begin
        out_valid_reg   <= 1'b1;
        out_ch_reg      <= gnt_idx;
        out_data_reg    <= sel_data;
        out_default_reg <= 1'b0;
        ptr_reg         <= gnt_inc;
      end else begin
        // Nothing to send: drop the slot and keep searching from the same place.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_ch      = out_ch_reg;
  assign out_default = out_default_reg;

endmodule

// File: tb/tb_tdm_slot_mux.sv
// Drives two multiplexers (4 channels with DEFAULT_VAL=F, 3 channels with 0)
// and compares every handshake and output against a slot-level reference model.
module tb_tdm_slot_mux;

  logic        clk = 1'b0;
  logic        rst, mode, out_ready;
  logic [3:0]  a_valid, a_ready, a_data;
  logic [15:0] a_in;
  logic [1:0]  a_ch;
  logic        a_ov, a_def;
  logic [2:0]  b_valid, b_ready;
  logic [11:0] b_in;
  logic [3:0]  b_data;
  logic [1:0]  b_ch;
  logic        b_ov, b_def;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model state, index 0 = 4-channel instance, index 1 = 3-channel instance.
  int          m_ptr [2];
  logic        m_ov  [2];
  logic [3:0]  m_od  [2];
  int          m_och [2];
  logic        m_def [2];

  always #5 clk = ~clk;

  tdm_slot_mux #(.WIDTH(4), .NUM_CH(4), .DEFAULT_VAL(4'hF)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(a_valid), .in_data(a_in),
    .in_ready(a_ready), .out_valid(a_ov), .out_ready(out_ready),
    .out_data(a_data), .out_ch(a_ch), .out_default(a_def)
  );

  tdm_slot_mux #(.WIDTH(4), .NUM_CH(3), .DEFAULT_VAL(4'h0)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(b_valid), .in_data(b_in),
    .in_ready(b_ready), .out_valid(b_ov), .out_ready(out_ready),
    .out_data(b_data), .out_ch(b_ch), .out_default(b_def)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One slot decision for a mux with n channels; rdy is the expected acknowledge.
  task automatic model(input int u, input int n, input logic [3:0] defv,
                       input logic r, input logic md, input logic [3:0] v,
                       input logic [15:0] d, input logic ordy, output logic [3:0] rdy);
    int found;
    int idx;
    rdy = '0;
    if (r) begin
      m_ptr[u] = 0; m_ov[u] = 0; m_od[u] = defv; m_och[u] = 0; m_def[u] = 0;
    end else if (!m_ov[u] || ordy) begin
      if (!md) begin
        m_och[u] = m_ptr[u];
        m_ov[u]  = 1;
        if (v[m_ptr[u]]) begin
          m_od[u] = d[m_ptr[u]*4 +: 4]; m_def[u] = 0; rdy[m_ptr[u]] = 1'b1;
        end else begin
          m_od[u] = defv; m_def[u] = 1;
        end
        m_ptr[u] = (m_ptr[u] + 1) % n;
      end else begin
        found = -1;
        for (int k = 0; k < n; k++) begin
          idx = (m_ptr[u] + k) % n;
          if (found < 0 && v[idx]) found = idx;
        end
        if (found >= 0) begin
          m_ov[u] = 1; m_od[u] = d[found*4 +: 4]; m_och[u] = found; m_def[u] = 0;
          rdy[found] = 1'b1;
          m_ptr[u] = (found + 1) % n;
        end else begin
          m_ov[u] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic md, input logic [3:0] va,
                      input logic [15:0] da, input logic [2:0] vb,
                      input logic [11:0] db, input logic ordy);
    logic [3:0] ra, rb;
    @(negedge clk);
    rst = r; mode = md; a_valid = va; a_in = da; b_valid = vb; b_in = db; out_ready = ordy;
    #1;
    model(0, 4, 4'hF, r, md, va, da, ordy, ra);
    model(1, 3, 4'h0, r, md, {1'b0, vb}, {4'h0, db}, ordy, rb);
    check("a_in_ready", 32'(a_ready), 32'(ra));
    check("b_in_ready", 32'(b_ready), 32'(rb[2:0]));
    @(posedge clk);
    #1;
    cyc++;
    check("a_out_valid", 32'(a_ov), 32'(m_ov[0]));
    check("a_out_data", 32'(a_data), 32'(m_od[0]));
    check("a_out_ch", 32'(a_ch), 32'(m_och[0]));
    check("a_out_default", 32'(a_def), 32'(m_def[0]));
    check("b_out_valid", 32'(b_ov), 32'(m_ov[1]));
    check("b_out_data", 32'(b_data), 32'(m_od[1]));
    check("b_out_ch", 32'(b_ch), 32'(m_och[1]));
    check("b_out_default", 32'(b_def), 32'(m_def[1]));
    $display("cyc %0d rst=%0b mode=%0b ordy=%0b | A v=%0b ch=%0d d=%h def=%0b | B v=%0b ch=%0d d=%h def=%0b",
             cyc, r, md, ordy, a_ov, a_ch, a_data, a_def, b_ov, b_ch, b_data, b_def);
  endtask

  initial begin
    logic [3:0] exp_seq [5];
    rst = 1'b1; mode = 1'b0; out_ready = 1'b1;
    a_valid = '0; a_in = '0; b_valid = '0; b_in = '0;
    for (int i = 0; i < 2; i++) m_ptr[i] = 0;

    step(1, 0, 4'b0000, 16'h0, 3'b000, 12'h0, 1);
    step(1, 0, 4'b1111, 16'h3210, 3'b111, 12'h210, 1);
    check("reset_out_valid", 32'(a_ov), 32'd0);
    check("reset_out_data", 32'(a_data), 32'hF);

    // Fixed mode, everything valid: strict rotation 0,1,2,3,0 (and 0,1,2,0 for 3 channels).
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'b1111, 16'h3210, 3'b111, 12'h210, 1);
      check("fixed_seq_data", 32'(a_data), 32'(exp_seq[i]));
      check("fixed_seq_ch", 32'(a_ch), 32'(exp_seq[i]));
    end

    // Fixed mode with idle slots.
    for (int i = 0; i < 6; i++) step(0, 0, 4'b0101, 16'h3210, 3'b101, 12'h210, 1);

    // Skip mode with only the outer channels requesting.
    for (int i = 0; i < 6; i++) step(0, 1, 4'b1001, 16'h3210, 3'b100, 12'h210, 1);
    step(0, 1, 4'b0000, 16'h3210, 3'b000, 12'h210, 1);

    // Back-pressure for three cycles, then release.
    step(0, 0, 4'b1111, 16'h7654, 3'b111, 12'h654, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 4'b1111, 16'h7654, 3'b111, 12'h654, 0);
    step(0, 0, 4'b1111, 16'h7654, 3'b111, 12'h654, 1);

    // Single-cycle reset mid-stream.
    step(0, 0, 4'b1111, 16'h3210, 3'b111, 12'h210, 1);
    step(1, 0, 4'b1111, 16'h3210, 3'b111, 12'h210, 1);
    check("midrst_out_valid", 32'(a_ov), 32'd0);
    step(0, 0, 4'b1111, 16'h3210, 3'b111, 12'h210, 1);
    check("post_rst_ch", 32'(a_ch), 32'd0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
           4'($urandom), 16'($urandom), 3'($urandom), 12'($urandom),
           ($urandom_range(0, 99) < 70));
      check("b_ch_in_range", 32'(b_ch < 2'd3), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
